// File: rtl/ysyx_24100006_wbu_pkg.sv
// Shared encodings for the ysyx_24100006 write-back stage and its CSR file.
// Optional mcycle counter: YSYX_24100006_MCYCLE_EN.
package ysyx_24100006_wbu_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  localparam logic [31:0] MSTATUS_RST_DEF = 32'h0000_1800;

  localparam logic [2:0] GSEL_ALU = 3'b000;
  localparam logic [2:0] GSEL_MEM = 3'b001;
  localparam logic [2:0] GSEL_PC4 = 3'b010;
  localparam logic [2:0] GSEL_IMM = 3'b011;
  localparam logic [2:0] GSEL_CSR = 3'b100;

  localparam logic [1:0] COP_RW  = 2'b00;
  localparam logic [1:0] COP_RS  = 2'b01;
  localparam logic [1:0] COP_RC  = 2'b10;
  localparam logic [1:0] COP_RW2 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } wbu_state_e;

  function automatic logic [31:0] csr_wval(
    input logic [1:0]  op,
    input logic [31:0] old,
    input logic [31:0] rs1
  );
    case (op)
      COP_RS:  csr_wval = old | rs1;
      COP_RC:  csr_wval = old & ~rs1;
      default: csr_wval = rs1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24100006_csr.sv
// Machine CSR file: registers, read mux, write ops and trap entry.
// Optional 64-bit mcycle counter under YSYX_24100006_MCYCLE_EN.
module ysyx_24100006_csr
  import ysyx_24100006_wbu_pkg::*;
#(
  parameter logic [31:0] MSTATUS_RST = MSTATUS_RST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_commit,
  input  logic        i_trap,
  input  logic        i_wen,
  input  logic [1:0]  i_op,
  input  logic [11:0] i_waddr,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_old,
  input  logic [31:0] i_pc,
  input  logic [7:0]  i_irq_no,
  input  logic [11:0] i_raddr,
  output logic [31:0] o_rdata,
  output logic [31:0] o_mtvec
);

  logic [31:0] r_mstatus;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] w_wdata;
  logic        w_wr;

  assign w_wdata = csr_wval(i_op, i_old, i_rs1);
  assign w_wr    = i_commit && i_wen && !i_trap;
  assign o_mtvec = r_mtvec;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mstatus <= MSTATUS_RST;
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_mcause  <= '0;
    end else if (i_commit && i_trap) begin
      r_mepc   <= i_pc;
      r_mcause <= {24'b0, i_irq_no};
    end else if (w_wr) begin
      case (i_waddr)
        CSR_MSTATUS: r_mstatus <= w_wdata;
        CSR_MTVEC:   r_mtvec   <= {w_wdata[31:2], 2'b00};
        CSR_MEPC:    r_mepc    <= w_wdata;
        CSR_MCAUSE:  r_mcause  <= w_wdata;
        default: ;
      endcase
    end
  end

`ifdef YSYX_24100006_MCYCLE_EN
  logic [63:0] r_mcycle;
  logic [63:0] w_mcycle_nxt;

  // A CSR write to either half overrides that half of the increment.
  always_comb begin
    w_mcycle_nxt = r_mcycle + 64'd1;
    if (w_wr && i_waddr == CSR_MCYCLE)
      w_mcycle_nxt[31:0] = w_wdata;
    if (w_wr && i_waddr == CSR_MCYCLEH)
      w_mcycle_nxt[63:32] = w_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) r_mcycle <= '0;
    else       r_mcycle <= w_mcycle_nxt;
  end
`endif

  always_comb begin
    o_rdata = '0;
    case (i_raddr)
      CSR_MSTATUS: o_rdata = r_mstatus;
      CSR_MTVEC:   o_rdata = r_mtvec;
      CSR_MEPC:    o_rdata = r_mepc;
      CSR_MCAUSE:  o_rdata = r_mcause;
`ifdef YSYX_24100006_MCYCLE_EN
      CSR_MCYCLE:  o_rdata = r_mcycle[31:0];
      CSR_MCYCLEH: o_rdata = r_mcycle[63:32];
`endif
      default:     o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_wbu.sv
// Write-back stage: GPR write-back, CSR commit, trap entry, IFU commit.
// Optional mcycle counter: YSYX_24100006_MCYCLE_EN.
module ysyx_24100006_wbu
  import ysyx_24100006_wbu_pkg::*;
#(
  parameter logic [31:0] MSTATUS_RST = MSTATUS_RST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        wb_ready,
  input  logic [31:0] pc_W,
  input  logic [31:0] sext_imm_W,
  input  logic [31:0] alu_result_W,
  input  logic [31:0] rs1_data_W,
  input  logic [31:0] rdata_csr_W,
  input  logic [31:0] Mem_rdata_extend,
  input  logic [4:0]  rd_W,
  input  logic        irq_W,
  input  logic [7:0]  irq_no_W,
  input  logic        Gpr_Write_W,
  input  logic [2:0]  Gpr_Write_RD_W,
  input  logic        Csr_Write_W,
  input  logic [1:0]  Csr_Write_RD_W,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        wb_valid,
  input  logic        ifu_ready,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  wbu_state_e  r_state;
  logic [31:0] r_pc;
  logic [11:0] r_csr_addr;
  logic [31:0] r_rs1;
  logic [31:0] r_rdata_csr;
  logic        r_irq;
  logic [7:0]  r_irq_no;
  logic        r_csr_we;
  logic [1:0]  r_csr_op;
  logic [31:0] w_gdata;
  logic [31:0] w_mtvec;
  logic        w_commit;

  always_comb begin
    w_gdata = '0;
    case (Gpr_Write_RD_W)
      GSEL_ALU: w_gdata = alu_result_W;
      GSEL_MEM: w_gdata = Mem_rdata_extend;
      GSEL_PC4: w_gdata = pc_W + 32'd4;
      GSEL_IMM: w_gdata = sext_imm_W;
      GSEL_CSR: w_gdata = rdata_csr_W;
      default:  w_gdata = '0;
    endcase
  end

  assign w_commit = (r_state == S_WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      wb_ready    <= 1'b1;
      wb_valid    <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      gpr_wen     <= 1'b0;
      gpr_waddr   <= '0;
      gpr_wdata   <= '0;
      r_pc        <= '0;
      r_csr_addr  <= '0;
      r_rs1       <= '0;
      r_rdata_csr <= '0;
      r_irq       <= 1'b0;
      r_irq_no    <= '0;
      r_csr_we    <= 1'b0;
      r_csr_op    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (mem_valid && wb_ready) begin
            r_pc        <= pc_W;
            r_csr_addr  <= sext_imm_W[11:0];
            r_rs1       <= rs1_data_W;
            r_rdata_csr <= rdata_csr_W;
            r_irq       <= irq_W;
            r_irq_no    <= irq_no_W;
            r_csr_we    <= Csr_Write_W;
            r_csr_op    <= Csr_Write_RD_W;
            gpr_wen     <= Gpr_Write_W && (rd_W != 5'd0);
            gpr_waddr   <= rd_W;
            gpr_wdata   <= w_gdata;
            wb_ready    <= 1'b0;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // mtvec still holds its pre-trap value on this edge
          gpr_wen     <= 1'b0;
          wb_valid    <= 1'b1;
          redirect    <= r_irq;
          redirect_pc <= w_mtvec;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (ifu_ready) begin
            wb_valid <= 1'b0;
            redirect <= 1'b0;
            wb_ready <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  ysyx_24100006_csr #(
    .MSTATUS_RST(MSTATUS_RST)
  ) u_csr (
    .clk      (clk),
    .reset    (reset),
    .i_commit (w_commit),
    .i_trap   (r_irq),
    .i_wen    (r_csr_we),
    .i_op     (r_csr_op),
    .i_waddr  (r_csr_addr),
    .i_rs1    (r_rs1),
    .i_old    (r_rdata_csr),
    .i_pc     (r_pc),
    .i_irq_no (r_irq_no),
    .i_raddr  (csr_raddr),
    .o_rdata  (csr_rdata),
    .o_mtvec  (w_mtvec)
  );

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Scoreboard bench for ysyx_24100006_wbu.
// Covers mcycle reads for both settings of YSYX_24100006_MCYCLE_EN.
module tb_ysyx_24100006_wbu;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        wb_ready;
  logic [31:0] pc_W, sext_imm_W, alu_result_W, rs1_data_W;
  logic [31:0] rdata_csr_W, Mem_rdata_extend;
  logic [4:0]  rd_W;
  logic        irq_W;
  logic [7:0]  irq_no_W;
  logic        Gpr_Write_W;
  logic [2:0]  Gpr_Write_RD_W;
  logic        Csr_Write_W;
  logic [1:0]  Csr_Write_RD_W;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        wb_valid;
  logic        ifu_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  ysyx_24100006_wbu dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .wb_ready(wb_ready),
    .pc_W(pc_W), .sext_imm_W(sext_imm_W), .alu_result_W(alu_result_W),
    .rs1_data_W(rs1_data_W), .rdata_csr_W(rdata_csr_W),
    .Mem_rdata_extend(Mem_rdata_extend), .rd_W(rd_W), .irq_W(irq_W),
    .irq_no_W(irq_no_W), .Gpr_Write_W(Gpr_Write_W),
    .Gpr_Write_RD_W(Gpr_Write_RD_W), .Csr_Write_W(Csr_Write_W),
    .Csr_Write_RD_W(Csr_Write_RD_W), .gpr_wen(gpr_wen),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata), .wb_valid(wb_valid), .ifu_ready(ifu_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_gdata(
    input logic [2:0] s, input logic [31:0] alu, mem, pc, imm, rc);
    case (s)
      3'd0: m_gdata = alu;
      3'd1: m_gdata = mem;
      3'd2: m_gdata = pc + 32'd4;
      3'd3: m_gdata = imm;
      3'd4: m_gdata = rc;
      default: m_gdata = 32'd0;
    endcase
  endfunction

  // monitor: pop one expectation per rising wb_valid
  int   wcnt = 0;
  logic pv = 1'b0;
  logic [4:0]  lw_a;
  logic [31:0] lw_d;
  exp_t me;
  always @(negedge clk) begin
    if (reset) wcnt = 0;
    else if (gpr_wen) begin
      wcnt++;
      lw_a = gpr_waddr;
      lw_d = gpr_wdata;
    end
    if (!reset && wb_valid && !pv) begin
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        me = q.pop_front();
        chk("sb_wcnt", wcnt, {63'd0, me.wen});
        if (me.wen) begin
          chk("sb_waddr", lw_a, me.waddr);
          chk("sb_wdata", lw_d, me.wdata);
        end
        chk("sb_redir", redirect, me.rd);
        if (me.rd) chk("sb_rpc", redirect_pc, me.rpc);
      end
      wcnt = 0;
    end
    pv = wb_valid;
  end

  task automatic rdcsr(input string tag, input logic [11:0] a,
                       input logic [31:0] exp);
    @(negedge clk);
    csr_raddr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic scramble();
    pc_W = $urandom; sext_imm_W = $urandom; alu_result_W = $urandom;
    rs1_data_W = $urandom; rdata_csr_W = $urandom;
    Mem_rdata_extend = $urandom; rd_W = 5'($urandom);
    irq_W = 1'b1; irq_no_W = 8'($urandom);
    Gpr_Write_W = 1'b1; Gpr_Write_RD_W = 3'($urandom);
    Csr_Write_W = 1'b1; Csr_Write_RD_W = 2'($urandom);
  endtask

  task automatic issue(
    input logic [31:0] pc, imm, alu, rs1, rc, mem,
    input logic [4:0] rd, input logic irq, input logic [7:0] ino,
    input logic gw, input logic [2:0] gs,
    input logic cw, input logic [1:0] cop, input int hold);
    exp_t e;
    logic [31:0] vh, wv;
    e.wen   = gw && (rd != 5'd0);
    e.waddr = rd;
    e.wdata = m_gdata(gs, alu, mem, pc, imm, rc);
    e.rd    = irq;
    e.rpc   = m_mtvec;
    @(negedge clk);
    chk("idle_rdy", wb_ready, 1);
    pc_W = pc; sext_imm_W = imm; alu_result_W = alu; rs1_data_W = rs1;
    rdata_csr_W = rc; Mem_rdata_extend = mem; rd_W = rd; irq_W = irq;
    irq_no_W = ino; Gpr_Write_W = gw; Gpr_Write_RD_W = gs;
    Csr_Write_W = cw; Csr_Write_RD_W = cop;
    mem_valid = 1'b1;
    ifu_ready = 1'b0;
    q.push_back(e);
    @(posedge clk); #1;
    scramble();
    chk("acc_rdy", wb_ready, 0);
    chk("lat1_wen", gpr_wen, e.wen);
    chk("lat1_vld", wb_valid, 0);
    @(posedge clk); #1;
    chk("lat2_vld", wb_valid, 1);
    chk("lat2_wen", gpr_wen, 0);
    vh = redirect_pc;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("bp_vld", wb_valid, 1);
      chk("bp_rpc", redirect_pc, vh);
      chk("bp_rdy", wb_ready, 0);
      chk("bp_wen", gpr_wen, 0);
    end
    mem_valid = 1'b0;
    ifu_ready = 1'b1;
    @(posedge clk); #1;
    ifu_ready = 1'b0;
    chk("hs_rdy", wb_ready, 1);
    chk("hs_vld", wb_valid, 0);
    if (irq) begin
      m_mepc = pc;
      m_mcause = {24'd0, ino};
    end else if (cw) begin
      case (cop)
        2'b01:   wv = rc | rs1;
        2'b10:   wv = rc & ~rs1;
        default: wv = rs1;
      endcase
      case (imm[11:0])
        12'h300: m_mstatus = wv;
        12'h305: m_mtvec = {wv[31:2], 2'b00};
        12'h341: m_mepc = wv;
        12'h342: m_mcause = wv;
        default: ;
      endcase
    end
  endtask

  task automatic m_reset();
    m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
  endtask

  task automatic chk_csrs(input string tag);
    rdcsr({tag, "_mstatus"}, 12'h300, m_mstatus);
    rdcsr({tag, "_mtvec"}, 12'h305, m_mtvec);
    rdcsr({tag, "_mepc"}, 12'h341, m_mepc);
    rdcsr({tag, "_mcause"}, 12'h342, m_mcause);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_valid = 1'b0; ifu_ready = 1'b0; csr_raddr = '0;
    scramble();
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst_rdy", wb_ready, 1);
    chk("rst_vld", wb_valid, 0);
    chk("rst_redir", redirect, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_wen", gpr_wen, 0);
    chk("rst_waddr", gpr_waddr, 0);
    chk("rst_wdata", gpr_wdata, 0);
    chk_csrs("rst");

    issue(32'h8000_0000, 32'h0, 32'h1234, 0, 0, 0,
          5'd5, 0, 0, 1, 3'd0, 0, 2'd0, 0);
    for (int s = 0; s < 8; s++)
      issue($urandom, 32'h0000_0FFF, $urandom, $urandom, $urandom,
            $urandom, 5'(1 + s), 0, 0, 1, 3'(s), 0, 2'd0, 0);
    issue(32'h8000_0004, 0, 32'hdead_beef, 0, 0, 0,
          5'd0, 0, 0, 1, 3'd0, 0, 2'd0, 0);
    issue(32'hFFFF_FFFC, 0, 0, 0, 0, 0,
          5'd9, 0, 0, 1, 3'd2, 0, 2'd0, 0);

    issue(32'h8000_0008, 32'h300, 0, 32'h8, 32'h1800, 0,
          5'd3, 0, 0, 1, 3'd4, 1, 2'd1, 0);
    rdcsr("csrrs_mstatus", 12'h300, 32'h1808);
    issue(32'h8000_000c, 32'h305, 0, 32'h8000_0103, 0, 0,
          5'd4, 0, 0, 0, 3'd0, 1, 2'd0, 0);
    issue(0, 32'h300, 0, 32'h800, 32'h1808, 0,
          5'd0, 0, 0, 0, 3'd0, 1, 2'd2, 0);
    issue(0, 32'h341, 0, 32'h1111_2222, 0, 0,
          5'd0, 0, 0, 0, 3'd0, 1, 2'd3, 1);
    issue(0, 32'h342, 0, 32'h10, 32'h3, 0,
          5'd0, 0, 0, 0, 3'd0, 1, 2'd1, 0);
    issue(0, 32'h123, 0, 32'hffff_ffff, 0, 0,
          5'd0, 0, 0, 0, 3'd0, 1, 2'd0, 0);
    rdcsr("unimpl_rd", 12'h123, 0);
    chk_csrs("csrops");

    issue(32'h8000_0010, 32'h300, 0, 32'hffff, 0, 0,
          5'd1, 1, 8'd11, 1, 3'd2, 1, 2'd0, 0);
    chk_csrs("trap");
    rdcsr("trap_mepc", 12'h341, 32'h8000_0010);
    rdcsr("trap_mcause", 12'h342, 32'd11);

    issue(32'h8000_0020, 32'h0, 32'h55, 0, 0, 0,
          5'd2, 1, 8'd7, 1, 3'd0, 0, 2'd0, 5);
    issue(32'h8000_0024, 32'h0, 32'h66, 0, 0, 0,
          5'd6, 0, 0, 1, 3'd0, 0, 2'd0, 5);
    chk_csrs("bp");

    // reset while in WRITE: pending mtvec write must not land
    @(negedge clk);
    sext_imm_W = 32'h305; rs1_data_W = 32'h1234_5670; Csr_Write_W = 1'b1;
    Csr_Write_RD_W = 2'd0; irq_W = 1'b0; Gpr_Write_W = 1'b1; rd_W = 5'd7;
    mem_valid = 1'b1;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk("rw_wen", gpr_wen, 1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rw_rdy", wb_ready, 1);
    chk("rw_wen0", gpr_wen, 0);
    chk("rw_vld", wb_valid, 0);
    @(negedge clk) reset = 1'b0;
    m_reset();
    repeat (10) @(posedge clk);
    #1 csr_raddr = 12'hB00;
    #1;
`ifdef YSYX_24100006_MCYCLE_EN
    chk("mcycle_lo", csr_rdata, 32'd10);
`else
    chk("mcycle_lo", csr_rdata, 32'd0);
`endif
    rdcsr("mcycle_hi", 12'hB80, 0);
    chk_csrs("rw");
    repeat (4) @(posedge clk);
    chk("rw_nocommit", wb_valid, 0);
    chk("sb_left", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_wbu.md
# ysyx_24100006_wbu

Write-back stage of the ysyx_24100006 multi-cycle core, directly downstream of the memory-access stage. Accepts one retired instruction per valid/ready handshake, selects the GPR write-back value, performs the GPR write, updates the machine CSR file, and enters the trap vector on `irq`. Signals instruction commit, plus any trap redirect, to the fetch unit. Owns the CSR file and exposes a combinational CSR read port to decode.

## Interface
Parameters:
- `MSTATUS_RST`, default 32'h0000_1800: mstatus reset value.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `mem_valid` in 1: upstream payload valid.
- `wb_ready` out 1: WBU can accept.
- `pc_W`, `sext_imm_W`, `alu_result_W`, `rs1_data_W`, `rdata_csr_W`, `Mem_rdata_extend` in 32 each: payload.
- `rd_W` in 5: GPR destination.
- `irq_W` in 1, `irq_no_W` in 8: trap request and cause.
- `Gpr_Write_W` in 1, `Gpr_Write_RD_W` in 3: GPR write enable and source select.
- `Csr_Write_W` in 1, `Csr_Write_RD_W` in 2: CSR write enable and write op.
- `gpr_wen` out 1, `gpr_waddr` out 5, `gpr_wdata` out 32: register-file write port.
- `csr_raddr` in 12, `csr_rdata` out 32: combinational CSR read.
- `wb_valid` out 1, `ifu_ready` in 1: commit handshake to IFU.
- `redirect` out 1, `redirect_pc` out 32: trap redirect, qualified by `wb_valid`.

## Operation
- GPR source select, `Gpr_Write_RD_W`:
  - 000: alu_result.
  - 001: Mem_rdata_extend.
  - 010: pc+4 (mod 2^32).
  - 011: sext_imm.
  - 100: rdata_csr.
  - 101–111: 0.
- CSR address is `sext_imm_W[11:0]`.
- CSR write op, `Csr_Write_RD_W`:
  - 00: rs1_data.
  - 01: rdata_csr | rs1_data.
  - 10: rdata_csr & ~rs1_data.
  - 11: rs1_data.
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
  - Reads of any other address return 0.
  - Writes to any other address are dropped.
  - mtvec[1:0] is forced to 0 on write.
- Trap when `irq_W`=1:
  - mepc←pc.
  - mcause←{24'b0, irq_no}.
  - redirect=1, redirect_pc=mtvec as it was before this instruction.
  - The trap suppresses any CSR write of the same instruction.
  - The GPR write still occurs if enabled.
- `gpr_wen` is forced to 0 when rd=0.
- FSM:
  - IDLE: `wb_ready`=1. On `mem_valid`&&`wb_ready`, latch all inputs, `wb_ready`←0, go to WRITE.
  - WRITE: exactly one cycle. `gpr_wen/waddr/wdata` are driven from the latched values and the CSR update commits on this cycle's closing edge. Then `wb_valid`←1, go to DONE.
  - DONE: hold `wb_valid`, `redirect` and `redirect_pc` stable until `ifu_ready`. On that edge: `wb_valid`←0, `wb_ready`←1, go to IDLE.
- `csr_rdata` always reflects the current CSR state. During WRITE it shows the pre-update value; there is no bypass.

## Timing
- Reset values:
  - `wb_ready`=1; `wb_valid`=0; `redirect`=0; `redirect_pc`=0.
  - `gpr_wen`=0; `gpr_waddr`=0; `gpr_wdata`=0.
  - mstatus=MSTATUS_RST; mtvec=mepc=mcause=0.
  - State IDLE.
- Latency: accept edge to `gpr_wen` high is 1 cycle. Accept to `wb_valid` high is 2 cycles.
- Minimum throughput: one instruction per 3 cycles when `ifu_ready` is held high.
- `gpr_wen` is high for exactly one cycle per accepted instruction with write enabled.
- Backpressure: `wb_ready` stays 0 from the accept edge until the `ifu_ready` handshake. The payload is sampled only on the accept edge, so upstream may change it afterwards.
- `mem_valid` in WRITE or DONE is ignored.
- Reset in any state returns to IDLE. Latched data is discarded and no GPR or CSR write follows.

## Configuration
- `YSYX_24100006_MCYCLE_EN` defined:
  - Adds a 64-bit mcycle counter, incremented every non-reset cycle and reset to 0.
  - Readable at 0xB00 (low word) and 0xB80 (high word); writable via the CSR ops.
  - On a cycle with both a write and an increment, the written value wins.
- Undefined: no counter; 0xB00 and 0xB80 read 0.

## Structure
- Shared package holds:
  - CSR address constants.
  - GPR source-select and CSR-op encodings.
  - FSM state encoding.
  - MSTATUS reset constant.
- One sub-module: `ysyx_24100006_csr`, containing the CSR registers, read mux, write-op logic, trap update and the optional mcycle counter.

## Test plan
- ALU write: alu=0x1234, sel=000, rd=5, Gpr_Write=1 -> one-cycle `gpr_wen` with waddr=5, wdata=0x1234; `wb_valid` 2 cycles after accept.
- rd=0 with Gpr_Write=1 -> `gpr_wen` stays 0; commit still signalled.
- csrrs at 0x300: rdata_csr=0x1800, rs1=0x8, op=01 -> mstatus=0x1808; a GPR write with sel=100 returns 0x1800.
- Trap: pc=0x8000_0010, irq_no=11, mtvec=0x8000_0100, Csr_Write=1 -> mepc=0x8000_0010, mcause=11, redirect_pc=0x8000_0100, CSR write dropped.
- Backpressure: `ifu_ready`=0 for 5 cycles -> `wb_valid` and `redirect_pc` held stable, `wb_ready`=0, new `mem_valid` ignored.
- Reset asserted in WRITE -> no CSR change, `wb_ready`=1 the next cycle; with MCYCLE_EN, a read of 0xB00 after 10 cycles out of reset returns 10.
